// File: rtl/mac_requant.sv
// Requantisation stage behind the MAC: round-half-up, arithmetic right shift and
// clamp of a wide accumulator into a narrow sample, as a two-stage elastic pipeline.
module mac_requant #(
    parameter int InWidth    = 48,
    parameter int OutWidth   = 8,
    parameter int OutSigned  = 0,
    parameter int ShiftWidth = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  valid_i,
    input  logic [InWidth-1:0]    acc_i,
    input  logic [ShiftWidth-1:0] shift_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [OutWidth-1:0]   data_o,
    output logic                  sat_o,
    input  logic                  ready_i,
    input  logic                  clear_i,
    output logic [15:0]           sat_count_o
);

    // One guard bit above the accumulator so adding the rounding term can never wrap.
    localparam int RoundWidth = InWidth + 1;
    localparam int MaxShift   = InWidth - 1;

    localparam logic signed [RoundWidth-1:0] MaxVal = (OutSigned != 0) ?
        RoundWidth'((64'd1 << (OutWidth - 1)) - 64'd1) :
        RoundWidth'((64'd1 << OutWidth) - 64'd1);
    localparam logic signed [RoundWidth-1:0] MinVal = (OutSigned != 0) ?
        RoundWidth'(64'hFFFF_FFFF_FFFF_FFFF << (OutWidth - 1)) :
        RoundWidth'(64'd0);
    localparam logic [15:0] CountMax = 16'hFFFF;

    // Half-LSB of the post-shift result; zero when no shift is applied.
    function automatic logic [RoundWidth-1:0] round_term(input logic [ShiftWidth-1:0] sh);
        logic [RoundWidth-1:0] one;
        one = {{(RoundWidth-1){1'b0}}, 1'b1};
        if (sh != {ShiftWidth{1'b0}}) begin
            round_term = one << (sh - {{(ShiftWidth-1){1'b0}}, 1'b1});
        end else begin
            round_term = {RoundWidth{1'b0}};
        end
    endfunction

    // Returns {clipped, value} after clamping q into the output range.
    function automatic logic [OutWidth:0] saturate(input logic signed [RoundWidth-1:0] q);
        if (q > MaxVal) begin
            saturate = {1'b1, MaxVal[OutWidth-1:0]};
        end else if (q < MinVal) begin
            saturate = {1'b1, MinVal[OutWidth-1:0]};
        end else begin
            saturate = {1'b0, q[OutWidth-1:0]};
        end
    endfunction

    logic                         s1_valid_r;
    logic signed [RoundWidth-1:0] s1_acc_r;
    logic [ShiftWidth-1:0]        s1_shift_r;
    logic                         s2_valid_r;
    logic [OutWidth-1:0]          s2_data_r;
    logic                         s2_sat_r;
    logic [15:0]                  sat_count_r;

    logic                         in_xfer_s;
    logic                         out_xfer_s;
    logic                         s1_adv_s;
    logic [ShiftWidth-1:0]        shift_clamp_s;
    logic signed [RoundWidth-1:0] rounded_s;
    logic signed [RoundWidth-1:0] shifted_s;
    logic [OutWidth:0]            clamp_s;

    assign ready_o     = !s1_valid_r || !s2_valid_r || ready_i;
    assign in_xfer_s   = valid_i && ready_o;
    assign out_xfer_s  = s2_valid_r && ready_i;
    assign s1_adv_s    = s1_valid_r && (!s2_valid_r || ready_i);

    assign valid_o     = s2_valid_r;
    assign data_o      = s2_data_r;
    assign sat_o       = s2_sat_r;
    assign sat_count_o = sat_count_r;

    // Clamp the shift amount to the widest meaningful right shift.
    always_comb begin
        shift_clamp_s = shift_i;
        if (32'(shift_i) > 32'(MaxShift)) begin
            shift_clamp_s = ShiftWidth'(MaxShift);
        end else begin
            shift_clamp_s = shift_i;
        end
    end

    // Sign-extend and add the rounding term ahead of the shift.
    always_comb begin
        rounded_s = $signed({acc_i[InWidth-1], acc_i} + round_term(shift_clamp_s));
    end

    // Arithmetic shift and clamp of the stage-1 value.
    always_comb begin
        shifted_s = s1_acc_r >>> s1_shift_r;
        clamp_s   = saturate(shifted_s);
    end

    // Stage 1: rounded accumulator and its shift amount.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_r <= 1'b0;
            s1_acc_r   <= '0;
            s1_shift_r <= '0;
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_acc_r   <= rounded_s;
            s1_shift_r <= shift_clamp_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: saturated output sample, held while downstream stalls.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_sat_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_data_r  <= clamp_s[OutWidth-1:0];
            s2_sat_r   <= clamp_s[OutWidth];
        end else if (out_xfer_s) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Sticky count of clipped beats delivered downstream; clear wins over increment.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sat_count_r <= 16'h0000;
        end else if (clear_i) begin
            sat_count_r <= 16'h0000;
        end else if (out_xfer_s && s2_sat_r && (sat_count_r != CountMax)) begin
            sat_count_r <= sat_count_r + 16'h0001;
        end else begin
            sat_count_r <= sat_count_r;
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: an unsigned and a signed build share one stimulus
// stream; expected values are hand-computed from the round/shift/clamp definition.
module tb_mac_requant;

    logic        clk;
    logic        reset_ni;
    logic        valid_i;
    logic [47:0] acc_i;
    logic [5:0]  shift_i;
    logic        ready_i;
    logic        clear_i;

    logic        ready_u, valid_u, sat_u;
    logic [7:0]  data_u;
    logic [15:0] cnt_u;
    logic        ready_s, valid_s, sat_s;
    logic [7:0]  data_s;
    logic [15:0] cnt_s;

    int checks   = 0;
    int failures = 0;

    mac_requant #(.InWidth(48), .OutWidth(8), .OutSigned(0), .ShiftWidth(6)) u_dut_u (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .acc_i(acc_i),
        .shift_i(shift_i), .ready_o(ready_u), .valid_o(valid_u), .data_o(data_u),
        .sat_o(sat_u), .ready_i(ready_i), .clear_i(clear_i), .sat_count_o(cnt_u)
    );

    mac_requant #(.InWidth(48), .OutWidth(8), .OutSigned(1), .ShiftWidth(6)) u_dut_s (
        .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .acc_i(acc_i),
        .shift_i(shift_i), .ready_o(ready_s), .valid_o(valid_s), .data_o(data_s),
        .sat_o(sat_s), .ready_i(ready_i), .clear_i(clear_i), .sat_count_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One beat with ready_i high; checks 2-cycle latency and the result on the chosen build.
    task automatic run_one(input string tag, input logic [47:0] acc, input logic [5:0] sh,
                           input logic [7:0] exp_d, input logic exp_sat, input bit sgn);
        @(negedge clk);
        valid_i = 1'b1;
        acc_i   = acc;
        shift_i = sh;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check_value({tag, "_lat"}, sgn ? valid_s : valid_u, 1'b0);
        @(posedge clk);
        #1;
        check_value({tag, "_v"}, sgn ? valid_s : valid_u, 1'b1);
        check_value({tag, "_d"}, sgn ? data_s : data_u, exp_d);
        check_value({tag, "_sat"}, sgn ? sat_s : sat_u, exp_sat);
    endtask

    initial begin
        int  in_idx;
        int  out_idx;
        int  cyc;
        bit  stalled;
        logic [7:0] held_d;

        reset_ni = 1'b0;
        valid_i  = 1'b0;
        acc_i    = 48'h0;
        shift_i  = 6'd0;
        ready_i  = 1'b1;
        clear_i  = 1'b0;
        #1;
        check_value("rst_valid", valid_u, 1'b0);
        check_value("rst_data", data_u, 8'h00);
        check_value("rst_sat", sat_u, 1'b0);
        check_value("rst_cnt", cnt_u, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        #1;
        check_value("rst_ready", ready_u, 1'b1);

        // Nominal unsigned
        run_one("nom0", 48'h1280, 6'd8, 8'h13, 1'b0, 1'b0);
        run_one("nom1", 48'h7F80, 6'd8, 8'h80, 1'b0, 1'b0);
        run_one("nom2", 48'h7F7F, 6'd8, 8'h7F, 1'b0, 1'b0);

        // Unsigned saturation
        run_one("satu0", 48'h1_2345, 6'd8, 8'hFF, 1'b1, 1'b0);
        run_one("satu1", 48'hFFFF_FFFF_FF00, 6'd8, 8'h00, 1'b1, 1'b0);
        run_one("satu2", 48'hFFFF_FFFF_FE80, 6'd8, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_value("satu_cnt", cnt_u, 16'd3);

        // Signed build (unsigned build clips the last three: count grows by 3)
        run_one("sgn0", 48'h7F80, 6'd8, 8'h7F, 1'b1, 1'b1);
        run_one("sgn1", 48'hFFFF_FFFF_FE80, 6'd8, 8'hFF, 1'b0, 1'b1);
        run_one("sgn2", 48'hFFFF_FFFF_8000, 6'd8, 8'h80, 1'b0, 1'b1);
        run_one("sgn3", 48'hFFFF_FFFF_7F00, 6'd8, 8'h80, 1'b1, 1'b1);

        // Boundary: clamped shift and shift of zero with the largest positive accumulator
        run_one("bnd_sh63", 48'h7FFF_FFFF_FFFF, 6'd63, 8'h01, 1'b0, 1'b0);
        run_one("bnd_sh0", 48'h7FFF_FFFF_FFFF, 6'd0, 8'hFF, 1'b1, 1'b0);
        run_one("bnd_sh0s", 48'h7FFF_FFFF_FFFF, 6'd0, 8'h7F, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_value("bnd_cnt", cnt_u, 16'd8);

        // Back-pressure: 16 beats, random ready_i
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_d  = 8'h00;
        while (out_idx < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            ready_i = 1'($urandom_range(0, 1));
            valid_i = (in_idx < 16);
            acc_i   = 48'(in_idx) << 8;
            shift_i = 6'd8;
            #1;
            if (stalled) begin
                check_value("bp_hold_v", valid_u, 1'b1);
                check_value("bp_hold_d", data_u, held_d);
            end
            check_value("bp_ready", ready_u, !(((in_idx - out_idx) == 2) && !ready_i));
            if (valid_u && ready_i) begin
                check_value("bp_order", data_u, 8'(out_idx));
                out_idx++;
            end
            stalled = valid_u && !ready_i;
            held_d  = data_u;
            if (valid_i && ready_u) in_idx++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check_value("bp_out_count", out_idx, 16);
        check_value("bp_in_count", in_idx, 16);
        repeat (3) @(posedge clk);

        // Fill both stages, then reset mid-stream
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1;
        acc_i   = 48'h1_2345;
        shift_i = 6'd8;
        @(negedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check_value("full_valid", valid_u, 1'b1);
        check_value("full_ready", ready_u, 1'b0);
        check_value("full_cnt", cnt_u, 16'd8);
        reset_ni = 1'b0;
        #1;
        check_value("mid_rst_valid", valid_u, 1'b0);
        check_value("mid_rst_cnt", cnt_u, 16'h0000);
        check_value("mid_rst_ready", ready_u, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        @(posedge clk);
        #1;
        check_value("post_rst_valid", valid_u, 1'b0);

        // Saturating stream long enough to pin the counter at its maximum
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b1;
        acc_i   = 48'h1_2345;
        shift_i = 6'd8;
        repeat (65540) @(negedge clk);
        #1;
        check_value("cnt_pinned", cnt_u, 16'hFFFF);
        check_value("clr_pre_v", valid_u, 1'b1);
        check_value("clr_pre_sat", sat_u, 1'b1);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        check_value("clr_cnt", cnt_u, 16'h0000);
        clear_i = 1'b0;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Downstream neighbour of the multiply-accumulate stage. Consumes its 48-bit two's-complement accumulator stream over valid/ready.
- Per beat: rounds, arithmetically right-shifts by a per-beat shift amount, and saturates to a narrow pixel/coefficient width (default 8-bit unsigned RGB channel).
- Two-stage elastic pipeline, full throughput, with a sticky saturation counter for debug.

Parameters:
- InWidth, 48, width of accumulator input (two's complement).
- OutWidth, 8, width of output sample; 2 <= OutWidth <= 32.
- OutSigned, 0, 0 = unsigned clamp [0, 2^OutWidth-1]; 1 = signed clamp [-2^(OutWidth-1), 2^(OutWidth-1)-1].
- ShiftWidth, 6, width of shift_i.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream data valid.
- acc_i  input  InWidth  signed accumulator from MAC.
- shift_i  input  ShiftWidth  right-shift amount, sampled with acc_i on handshake; values > InWidth-1 treated as InWidth-1.
- ready_o  output  1  block can accept a beat.
- valid_o  output  1  output data valid.
- data_o  output  OutWidth  rounded, shifted, saturated result.
- sat_o  output  1  beat on data_o was clipped.
- ready_i  input  1  downstream ready.
- clear_i  input  1  synchronous clear of sat_count_o.
- sat_count_o  output  16  number of clipped beats accepted downstream, saturating at 0xFFFF.

Behaviour:
- Reset: reset_ni low asynchronously clears both stage valids, data_o = 0, sat_o = 0, sat_count_o = 0. ready_o = 1 after reset. A reset mid-stream drops in-flight beats; no partial output.
- Handshakes:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
  - valid_o must not depend combinationally on ready_i.
  - While valid_o && !ready_i, data_o and sat_o hold stable.
- Stage 1 (round):
  - On input transfer, register r = sext(acc_i, InWidth+1) + (s > 0 ? 2^(s-1) : 0), where s = clamped shift.
  - Register s alongside r. Set s1_valid.
  - The extra bit guarantees no wrap at +max.
  - Rounding is round-half-up (toward +inf).
- Stage 2 (shift + saturate):
  - q = r >>> s (arithmetic).
  - Clamp q to the OutWidth range selected by OutSigned.
  - sat = 1 iff clamping changed the value. Register data_o, sat_o, s2_valid.
- Advance rules:
  - s2 loads when s1_valid && (!s2_valid || ready_i).
  - s1 loads on input transfer.
  - ready_o = !s1_valid || !s2_valid || ready_i (combinational pass-through of ready_i is allowed).
  - s1 and s2 update in the same cycle when both advance.
  - s2_valid clears on output transfer if s1 is not advancing.
- Latency and throughput:
  - Latency: 2 cycles from input transfer to valid_o with no back-pressure.
  - Throughput: 1 beat/cycle with ready_i held high.
  - No beat is dropped or duplicated under any ready_i pattern.
- Saturation counter:
  - Increments on output transfer with sat_o = 1.
  - Holds at 0xFFFF.
  - clear_i has priority: clear and increment in the same cycle gives 0.
- Shift = 0: no rounding term; pure clamp.

Test Plan:
- Nominal, unsigned, OutWidth=8, shift=8: acc 0x1280 -> 0x13, sat 0; acc 0x7F80 -> 0x80; acc 0x7F7F -> 0x7F; each appears 2 cycles after handshake.
- Saturation, unsigned: acc 0x12345 shift 8 -> 0xFF sat 1; acc -0x100 -> 0x00 sat 1; acc -0x180 -> rounds to -1 -> 0x00 sat 1; sat_count_o = 3.
- Signed build, OutSigned=1, OutWidth=8, shift 8:
  - acc 0x7F80 -> 0x7F sat 1.
  - acc -0x180 -> 0xFF (-1) sat 0.
  - acc -0x8000 -> 0x80 sat 0.
  - acc -0x8100 -> 0x80 sat 1.
- Back-pressure: 16 back-to-back beats (acc = i<<8, shift 8) with ready_i random 50%. Required: output sequence 0..15 in order, no loss or duplication, data_o stable while stalled, ready_o low only when both stages are full and ready_i = 0.
- Boundary: shift_i = 63 with acc = 2^47-1 -> shift clamped to 47, result 1 (unsigned). acc = 2^47-1 with shift 0 -> 0xFF sat 1, no overflow in the round stage.
- Reset and clear:
  - Assert reset_ni low with both stages full: valid_o drops immediately and sat_count_o = 0.
  - Drive 0x10000 saturating beats: counter holds 0xFFFF.
  - Pulse clear_i coincident with a saturating transfer: counter = 0.
